matrix2x2_rr_sched: RTL and testbench
=====================================

# matrix2x2_rr_sched

Round-robin scheduler and sequencer for the 2x2 matrix-multiply resource. Two independent requesters submit packed operand pairs (A, B) over valid/ready handshakes. The block arbitrates between them and computes C = A x B on one shared multiply-accumulate, one product per cycle. It returns the packed result with the requester ID over a valid/ready output handshake. It sits between the operand sources and the consumer of the 32-bit packed result, as the sequential, shared counterpart of the parallel 2x2 multiplier.

## Interface
- EW, 8, element width; operand and result buses are 4*EW bits wide.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (rst = 0 resets).
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a, req0_b  in  4*EW  requester 0 operands; packed {m00, m01, m10, m11}, with m00 in the MSBs.
- req0_ready  out  1  requester 0 operands accepted this edge if valid.
- req1_valid, req1_a, req1_b, req1_ready: identical for requester 1.
- res_valid  out  1  result available.
- res  out  4*EW  packed {c00, c01, c10, c11}.
- res_id  out  1  requester that owns res.
- res_ovf  out  1  at least one element sum exceeded 2^EW-1.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  state is not IDLE.

## Operation
- State machine has three states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE (arbitration):
  - If exactly one reqN_valid is high, grant N.
  - If both are high, grant the requester not granted last. last_grant resets to 1, so requester 0 wins the first tie.
  - reqN_ready = (state == IDLE) & rst & grant == N. It is combinational and may depend on the other requester's valid.
  - At most one ready is high at a time.
- Accept: on an edge with reqN_valid & reqN_ready:
  - Latch A, B and id = N.
  - Set last_grant = N.
  - Clear the 5-bit cnt and the accumulator.
  - Go to CALC.
- CALC runs 8 cycles. cnt[2:1] selects the element k (0 = c00, 1 = c01, 2 = c10, 3 = c11). cnt[0] selects the term t.
  - Element c_ij = a_i0*b_0j + a_i1*b_1j, unsigned.
  - The t = 0 cycle loads acc = a_i0*b_0j.
  - The t = 1 cycle computes acc + a_i1*b_1j as a 2*EW+1-bit sum. The low EW bits are written to element k of the result register (modulo 2^EW). ovf_acc is ORed with the sum's bits above EW-1.
  - After the cnt = 7 cycle: go to DONE, drive res_ovf = ovf_acc, and set res_id = id.
- DONE:
  - res_valid = 1. res, res_id and res_ovf are held stable until the handshake.
  - On an edge with res_valid & res_ready: go to IDLE.
  - res, res_id and res_ovf hold their last values; only res_valid drops.
- Requester operands are sampled only at the accept edge. Changing reqN_a or reqN_b afterwards has no effect.
- A reqN_valid that drops before it is granted is simply not served. There is no queueing.

## Timing
- Reset values: res_valid 0, res 0, res_id 0, res_ovf 0, busy 0, req0_ready 0, req1_ready 0, last_grant 1, cnt 0.
- Reset is asserted asynchronously and released synchronously.
- Reset during CALC or DONE discards the in-flight operation. No res_valid pulse follows, and the requester is not retried.
- Latency: an accept at edge N gives res_valid high after edge N+8.
- Minimum issue period is 10 cycles. res_ready held high gives the result handshake at edge N+9 and the next accept at edge N+10.
- res_ready low holds DONE indefinitely. Both req*_ready stay 0 meanwhile.
- A requester whose valid is held high across its own grant is served at most once per accept. Under back-to-back requests from both requesters, grants alternate 0, 1, 0, 1, ...
- busy goes high after the accept edge and low after the result-handshake edge.

## Test plan
- Basic: reset, then req0 with A = {1,2,3,4}, B = {5,6,7,8}, res_ready = 1 -> req0_ready = 1 in IDLE. res = 0x13162B32 (19, 22, 43, 50), res_id = 0, res_ovf = 0, res_valid after edge N+8, one cycle wide.
- Identity/overflow: A = {1,0,0,1}, B = 0xDEADBEEF -> res = 0xDEADBEEF, res_ovf = 0. A = B = 0xFFFFFFFF -> res = 0x02020202, res_ovf = 1.
- Arbitration: both valid from reset, with distinct operands, for 4 ops -> grant order 0, 1, 0, 1. Each res_id matches its requester's result. Only one ready is ever high.
- Backpressure: res_ready = 0 for 20 cycles after res_valid -> res stable, busy = 1, no ready asserted. res_ready = 1 -> IDLE on the next edge, and the next accept follows.
- Reset mid-op: drop rst at cnt = 4 -> all outputs return to their reset values immediately. After release, a fresh request completes correctly with no stale res_valid.
- Operand isolation: change req0_a and req0_b every cycle during CALC -> the result matches the values latched at accept.

Source files
------------

// File: rtl/matrix2x2_rr_sched.sv
// Round-robin scheduler for a shared 2x2 matrix multiply.
// One MAC per cycle, eight cycles per product, result returned with the owning requester id.
module matrix2x2_rr_sched #(
   parameter int EW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   input  logic [4*EW-1:0] req0_a,
   input  logic [4*EW-1:0] req0_b,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [4*EW-1:0] req1_a,
   input  logic [4*EW-1:0] req1_b,
   output logic            req1_ready,
   output logic            res_valid,
   output logic [4*EW-1:0] res,
   output logic            res_id,
   output logic            res_ovf,
   input  logic            res_ready,
   output logic            busy
);

   // state | meaning
   // IDLE  | arbitrate between requesters, accept one operand pair
   // CALC  | eight MAC cycles, two per result element (cnt[2:1] element, cnt[0] term)
   // DONE  | result presented, waiting for res_ready
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam int W = 4 * EW;

   state_t            state_q, state_d;
   logic [W-1:0]      a_q, b_q, work, work_upd, res_q;
   logic              id_q, last_grant, grant, accept;
   logic [4:0]        cnt;
   logic [2*EW-1:0]   acc, prod;
   logic [2*EW:0]     sum;
   logic              ovf_acc, elem_ovf, res_id_q, res_ovf_q;
   logic [EW-1:0]     ma, mb;
   logic [1:0]        k;
   logic              t;

   function automatic logic [EW-1:0] elem(input logic [W-1:0] m, input logic [1:0] idx);
      logic [EW-1:0] e;
      case (idx)
         2'd0:    e = m[4*EW-1:3*EW];
         2'd1:    e = m[3*EW-1:2*EW];
         2'd2:    e = m[2*EW-1:EW];
         default: e = m[EW-1:0];
      endcase
      return e;
   endfunction

   // Tie goes to the requester not served last; with no valids the same rule picks the idle owner.
   always_comb begin
      grant = ~last_grant;
      if (req0_valid && !req1_valid)
         grant = 1'b0;
      else if (req1_valid && !req0_valid)
         grant = 1'b1;
   end

   assign req0_ready = (state_q == IDLE) & rst & ~grant;
   assign req1_ready = (state_q == IDLE) & rst & grant;
   assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

   assign k        = cnt[2:1];
   assign t        = cnt[0];
   assign ma       = elem(a_q, {k[1], t});
   assign mb       = elem(b_q, {t, k[0]});
   assign prod     = {{EW{1'b0}}, ma} * {{EW{1'b0}}, mb};
   assign sum      = {1'b0, acc} + {1'b0, prod};
   assign elem_ovf = |sum[2*EW:EW];

   always_comb begin
      work_upd = work;
      case (k)
         2'd0:    work_upd[4*EW-1:3*EW] = sum[EW-1:0];
         2'd1:    work_upd[3*EW-1:2*EW] = sum[EW-1:0];
         2'd2:    work_upd[2*EW-1:EW]   = sum[EW-1:0];
         default: work_upd[EW-1:0]      = sum[EW-1:0];
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = CALC;
         CALC:    if (cnt == 5'd7) state_d = DONE;
         DONE:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
         acc        <= '0;
         ovf_acc    <= 1'b0;
         work       <= '0;
         res_q      <= '0;
         res_id_q   <= 1'b0;
         res_ovf_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               a_q        <= grant ? req1_a : req0_a;
               b_q        <= grant ? req1_b : req0_b;
               id_q       <= grant;
               last_grant <= grant;
               cnt        <= '0;
               acc        <= '0;
               ovf_acc    <= 1'b0;
            end
            CALC: begin
               cnt <= cnt + 5'd1;
               if (!t) begin
                  acc <= prod;
               end else begin
                  work    <= work_upd;
                  ovf_acc <= ovf_acc | elem_ovf;
               end
               // Outputs only change here so they stay stable through CALC and after DONE.
               if (cnt == 5'd7) begin
                  res_q     <= work_upd;
                  res_ovf_q <= ovf_acc | elem_ovf;
                  res_id_q  <= id_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign res_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign res       = res_q;
   assign res_id    = res_id_q;
   assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_matrix2x2_rr_sched.sv
// Scoreboard bench for matrix2x2_rr_sched: expected results are queued at accept
// from a reference matrix product and compared at each result handshake.
module tb_matrix2x2_rr_sched;

   logic        clk;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_ready, req1_ready;
   logic        res_valid, res_id, res_ovf, res_ready, busy;
   logic [31:0] res;

   int n_checks = 0;
   int n_fail   = 0;
   int n_acc    = 0;
   logic [33:0] sb[$];
   logic        got_ids[$];

   matrix2x2_rr_sched #(.EW(8)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .res_valid(res_valid), .res(res), .res_id(res_id), .res_ovf(res_ovf),
      .res_ready(res_ready), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ae(input logic [31:0] x, input int idx);
      return int'(x[31-8*idx -: 8]);
   endfunction

   // {id, ovf, res}
   function automatic logic [33:0] model(input logic id, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        ovf;
      int          s;
      r   = '0;
      ovf = 1'b0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            s = ae(a, 2*i) * ae(b, j) + ae(a, 2*i+1) * ae(b, 2+j);
            r[31-8*(2*i+j) -: 8] = s[7:0];
            if (s > 255) ovf = 1'b1;
         end
      return {id, ovf, r};
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         n_checks++;
         if (req0_ready && req1_ready) begin
            n_fail++;
            $display("FAIL one_ready: req0_ready=%0b req1_ready=%0b, required at most one", req0_ready, req1_ready);
         end
         if (req0_valid && req0_ready) begin
            sb.push_back(model(1'b0, req0_a, req0_b));
            n_acc++;
         end
         if (req1_valid && req1_ready) begin
            sb.push_back(model(1'b1, req1_a, req1_b));
            n_acc++;
         end
         if (res_valid && res_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_result: id=%0b res=%h, required no result", res_id, res);
            end else begin
               logic [33:0] exp;
               exp = sb.pop_front();
               if ({res_id, res_ovf, res} !== exp) begin
                  n_fail++;
                  $display("FAIL result: id=%0b ovf=%0b res=%h, required id=%0b ovf=%0b res=%h",
                           res_id, res_ovf, res, exp[33], exp[32], exp[31:0]);
               end
               got_ids.push_back(res_id);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int c;
      c = 0;
      while ((busy || sb.size() != 0) && c < budget) begin
         tick();
         c++;
      end
      n_checks++;
      if (busy || sb.size() != 0) begin
         n_fail++;
         $display("FAIL idle_timeout: busy=%0b pending=%0d, required idle and empty", busy, sb.size());
      end
   endtask

   task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b);
      bit ok;
      ok = 0;
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
      for (int c = 0; c < 20 && !ok; c++) begin
         if (id ? req1_ready : req0_ready) ok = 1;
         else tick();
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL grant_timeout: id=%0b never granted, required grant", id);
      end
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle(40);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req0_valid = 0; req1_valid = 0; res_ready = 0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      #3;
      n_checks++;
      if ({res_valid, res, res_id, res_ovf, busy, req0_ready, req1_ready} !== 38'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%0b res=%h id=%0b ovf=%0b busy=%0b r0=%0b r1=%0b, required all 0",
                  res_valid, res, res_id, res_ovf, busy, req0_ready, req1_ready);
      end
      tick();
      tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: r0=%0b r1=%0b busy=%0b, required 1 0 0", req0_ready, req1_ready, busy);
      end
   endtask

   task automatic test_basic();
      res_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 32'h01020304; req0_b = 32'h05060708;
      #1;
      n_checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_ready: r0=%0b r1=%0b, required 1 0", req0_ready, req1_ready);
      end
      tick();
      req0_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_busy: busy=%0b, required 1", busy);
      end
      repeat (7) tick();
      n_checks++;
      if (res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_early: res_valid=%0b after edge N+7, required 0", res_valid);
      end
      tick();
      n_checks++;
      if (res_valid !== 1'b1 || res !== 32'h13162B32 || res_id !== 1'b0 || res_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_result: valid=%0b res=%h id=%0b ovf=%0b, required 1 13162b32 0 0",
                  res_valid, res, res_id, res_ovf);
      end
      tick();
      n_checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_width: valid=%0b busy=%0b after N+9, required 0 0", res_valid, busy);
      end
      wait_idle(10);
   endtask

   task automatic test_overflow();
      res_ready = 1'b1;
      run_op(1'b0, 32'h01000001, 32'hDEADBEEF);
      n_checks++;
      if (res !== 32'hDEADBEEF || res_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL identity: res=%h ovf=%0b, required deadbeef 0", res, res_ovf);
      end
      run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      n_checks++;
      if (res !== 32'h02020202 || res_ovf !== 1'b1 || res_id !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow: res=%h ovf=%0b id=%0b, required 02020202 1 1", res, res_ovf, res_id);
      end
   endtask

   task automatic test_arbitration();
      logic exp_ids [4];
      int   start;
      exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
      rst = 1'b0;
      tick();
      rst = 1'b1;
      got_ids.delete();
      start = n_acc;
      res_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 32'h01020304; req0_b = 32'h05060708;
      req1_valid = 1'b1; req1_a = 32'h0A090807; req1_b = 32'h02030405;
      for (int c = 0; c < 200 && n_acc < start + 4; c++) tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_idle(40);
      n_checks++;
      if (got_ids.size() != 4) begin
         n_fail++;
         $display("FAIL arb_count: results=%0d, required 4", got_ids.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_ids[i] !== exp_ids[i]) begin
               n_fail++;
               $display("FAIL arb_order: op %0d id=%0b, required %0b", i, got_ids[i], exp_ids[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] snap;
      int c;
      res_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 32'h03050709; req0_b = 32'h02040608;
      n_checks++;
      if (req0_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_ready: req0_ready=%0b, required 1", req0_ready);
      end
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 32'h01010101; req1_b = 32'h02020202;
      c = 0;
      while (!res_valid && c < 20) begin tick(); c++; end
      n_checks++;
      if (!res_valid) begin
         n_fail++;
         $display("FAIL bp_timeout: res_valid=%0b, required 1", res_valid);
      end
      snap = res;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_checks++;
         if (res !== snap || res_valid !== 1'b1 || busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: cycle %0d res=%h valid=%0b busy=%0b r0=%0b r1=%0b, required %h 1 1 0 0",
                     i, res, res_valid, busy, req0_ready, req1_ready, snap);
         end
      end
      res_ready = 1'b1;
      tick();
      n_checks++;
      if (res_valid !== 1'b0 || req1_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: valid=%0b req1_ready=%0b, required 0 1", res_valid, req1_ready);
      end
      tick();
      req1_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_next_accept: busy=%0b, required 1", busy);
      end
      wait_idle(40);
   endtask

   task automatic test_reset_mid();
      res_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 32'h11223344; req0_b = 32'h01020304;
      tick();
      req0_valid = 1'b0;
      repeat (4) tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if ({res_valid, res, res_id, res_ovf, busy, req0_ready, req1_ready} !== 38'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: valid=%0b res=%h id=%0b ovf=%0b busy=%0b r0=%0b r1=%0b, required all 0",
                  res_valid, res, res_id, res_ovf, busy, req0_ready, req1_ready);
      end
      sb.delete();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_stale: valid=%0b busy=%0b, required 0 0", res_valid, busy);
         end
      end
      run_op(1'b1, 32'h02030405, 32'h06070809);
   endtask

   task automatic test_isolation();
      logic [31:0] a0, b0;
      logic [33:0] exp;
      a0 = 32'h0A0B0C0D; b0 = 32'h01020304;
      exp = model(1'b0, a0, b0);
      res_ready = 1'b1;
      req0_valid = 1'b1; req0_a = a0; req0_b = b0;
      tick();
      req0_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         req0_a = $urandom;
         req0_b = $urandom;
         tick();
      end
      wait_idle(20);
      n_checks++;
      if (res !== exp[31:0] || res_ovf !== exp[32]) begin
         n_fail++;
         $display("FAIL isolation: res=%h ovf=%0b, required %h %0b", res, res_ovf, exp[31:0], exp[32]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_arbitration();
      test_backpressure();
      test_reset_mid();
      test_isolation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
